// File: rtl/data_packer_block.sv
// data_packer_block: packs an 8-bit valid/ready byte stream into words of
// BYTES_PER_WORD bytes. Each word is tagged with its byte count. A flush
// request sends out a partial word early. A 16-bit counter tracks the
// number of words handed off downstream.
// Optional feature: define PACKER_CHECKSUM_EN to add a checksum[7:0] output
// port. It carries the modulo-256 sum of the bytes in the current word.
module data_packer_block #(
  parameter int unsigned BYTES_PER_WORD = 4,
  parameter int unsigned CNT_W          = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  output logic                        ready_in,
  input  logic [7:0]                  data_in,
  input  logic                        flush,
  output logic                        valid_out,
  input  logic                        ready_out,
  output logic [8*BYTES_PER_WORD-1:0] word_out,
  output logic [CNT_W-1:0]            byte_cnt,
  output logic [15:0]                 words_sent
`ifdef PACKER_CHECKSUM_EN
  ,
  output logic [7:0]                  checksum
`endif
);

  localparam int unsigned WordW = 8 * BYTES_PER_WORD;
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(BYTES_PER_WORD);

  typedef enum logic [0:0] {StFill, StEmit} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   fill_inc;
  logic [WordW-1:0]   word_q, word_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        sent_q, sent_d;
`ifdef PACKER_CHECKSUM_EN
  logic [7:0]         sum_q, sum_d;
`endif

  assign fill_inc = fill_q + CNT_W'(1);

  // Next-state: byte packing in FILL, word hand-off in EMIT.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    sent_d  = sent_q;
`ifdef PACKER_CHECKSUM_EN
    sum_d   = sum_q;
`endif
    unique case (state_q)
      StFill: begin
        if (valid_in) begin
          // Steer the byte into the lane selected by the current fill count.
          for (int k = 0; k < int'(BYTES_PER_WORD); k++) begin
            if (fill_q == CNT_W'(k)) word_d[8*k +: 8] = data_in;
          end
          fill_d = fill_inc;
`ifdef PACKER_CHECKSUM_EN
          sum_d  = sum_q + data_in;
`endif
          // A flush on the same edge still includes the byte being accepted.
          if (fill_inc == FullCnt || flush) begin
            state_d = StEmit;
            cnt_d   = fill_inc;
          end
        end else if (flush && fill_q != '0) begin
          state_d = StEmit;
          cnt_d   = fill_q;
        end
      end
      StEmit: begin
        // Flush is ignored here; only the downstream handshake leaves EMIT.
        if (ready_out) begin
          state_d = StFill;
          fill_d  = '0;
          word_d  = '0;
          cnt_d   = '0;
          sent_d  = sent_q + 16'd1;
`ifdef PACKER_CHECKSUM_EN
          sum_d   = '0;
`endif
        end
      end
      default: state_d = StFill;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StFill;
      fill_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      sent_q  <= '0;
`ifdef PACKER_CHECKSUM_EN
      sum_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      sent_q  <= sent_d;
`ifdef PACKER_CHECKSUM_EN
      sum_q   <= sum_d;
`endif
    end
  end

  // Outputs are decoded only from registered state.
  always_comb begin
    ready_in   = (state_q == StFill);
    valid_out  = (state_q == StEmit);
    word_out   = word_q;
    byte_cnt   = cnt_q;
    words_sent = sent_q;
`ifdef PACKER_CHECKSUM_EN
    checksum   = sum_q;
`endif
  end

endmodule

// File: tb/tb_data_packer_block.sv
// Testbench for data_packer_block at its default configuration (4 bytes per word).
// It runs fixed vectors, some hand-written corner-case sequences and
// randomized traffic. Every cycle it also checks the DUT against a
// queue-based reference model.
module tb_data_packer_block;

  localparam int unsigned BPW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic [7:0]  data_in;
  logic        flush;
  logic        valid_out;
  logic        ready_out;
  logic [31:0] word_out;
  logic [3:0]  byte_cnt;
  logic [15:0] words_sent;
`ifdef PACKER_CHECKSUM_EN
  logic [7:0]  checksum;
`endif

  data_packer_block #(.BYTES_PER_WORD(BPW), .CNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_in   (valid_in),
    .ready_in   (ready_in),
    .data_in    (data_in),
    .flush      (flush),
    .valid_out  (valid_out),
    .ready_out  (ready_out),
    .word_out   (word_out),
    .byte_cnt   (byte_cnt),
    .words_sent (words_sent)
`ifdef PACKER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: bytes of the word being built, and whether it is on offer.
  logic [7:0]  m_buf[$];
  bit          m_emit = 1'b0;
  logic [15:0] m_sent = 16'd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_edge(logic r, logic v, logic [7:0] d, logic f, logic ro);
    if (!r) begin
      m_buf.delete();
      m_emit = 1'b0;
      m_sent = 16'd0;
    end else if (m_emit) begin
      if (ro) begin
        m_emit = 1'b0;
        m_buf.delete();
        m_sent = m_sent + 16'd1;
      end
    end else if (v) begin
      m_buf.push_back(d);
      if (m_buf.size() == BPW || f) m_emit = 1'b1;
    end else if (f && m_buf.size() > 0) begin
      m_emit = 1'b1;
    end
  endfunction

  task automatic check_model();
    logic [31:0] w;
    logic [7:0]  s;
    w = '0;
    s = '0;
    foreach (m_buf[i]) begin
      w[8*i +: 8] = m_buf[i];
      s = s + m_buf[i];
    end
    chk("model_valid_out", 64'(valid_out), 64'(m_emit));
    chk("model_ready_in", 64'(ready_in), 64'(!m_emit));
    chk("model_word_out", 64'(word_out), 64'(w));
    chk("model_byte_cnt", 64'(byte_cnt), m_emit ? 64'(m_buf.size()) : 64'd0);
    chk("model_words_sent", 64'(words_sent), 64'(m_sent));
`ifdef PACKER_CHECKSUM_EN
    chk("model_checksum", 64'(checksum), 64'(s));
`endif
  endtask

  // Drive inputs for one cycle, advance the model at the edge, sample #1 later.
  task automatic step(input logic r, input logic v, input logic [7:0] d, input logic f,
                      input logic ro);
    rst = r; valid_in = v; data_in = d; flush = f; ready_out = ro;
    @(posedge clk);
    model_edge(r, v, d, f, ro);
    #1;
    check_model();
  endtask

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        f;
    logic        ro;
    logic        e_vo;
    logic [31:0] e_word;
    logic [3:0]  e_cnt;
    logic        e_rdy;
    logic [15:0] e_sent;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_w;
    logic [15:0] held_s;

    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 32'h0000_0011, 4'd0, 1'b1, 16'd0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 32'h0000_2211, 4'd0, 1'b1, 16'd0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b0, 32'h0033_2211, 4'd0, 1'b1, 16'd0};
    tbl[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 32'h4433_2211, 4'd4, 1'b0, 16'd0};
    tbl[4]  = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'd0, 1'b1, 16'd1};
    tbl[5]  = '{1'b1, 8'hA1, 1'b0, 1'b0, 1'b0, 32'h0000_00A1, 4'd0, 1'b1, 16'd1};
    tbl[6]  = '{1'b1, 8'hB2, 1'b0, 1'b0, 1'b0, 32'h0000_B2A1, 4'd0, 1'b1, 16'd1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_B2A1, 4'd2, 1'b0, 16'd1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 32'h0000_B2A1, 4'd2, 1'b0, 16'd1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'd0, 1'b1, 16'd2};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 4'd0, 1'b1, 16'd2};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 4'd0, 1'b1, 16'd2};
    tbl[12] = '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 32'h0000_00C3, 4'd0, 1'b1, 16'd2};
    tbl[13] = '{1'b1, 8'hD4, 1'b1, 1'b0, 1'b1, 32'h0000_D4C3, 4'd2, 1'b0, 16'd2};
    tbl[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'd0, 1'b1, 16'd3};

    rst = 1'b0; valid_in = 1'b0; data_in = '0; flush = 1'b0; ready_out = 1'b0;

    // Reset hold with a byte on offer.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
      chk("reset_valid_out", 64'(valid_out), 64'd0);
      chk("reset_word_out", 64'(word_out), 64'd0);
      chk("reset_words_sent", 64'(words_sent), 64'd0);
    end

    // Table: full word, flush partial, flush in EMIT, empty flush, flush with accept.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].ro);
      chk($sformatf("tbl%0d_valid_out", i), 64'(valid_out), 64'(tbl[i].e_vo));
      chk($sformatf("tbl%0d_word_out", i), 64'(word_out), 64'(tbl[i].e_word));
      chk($sformatf("tbl%0d_byte_cnt", i), 64'(byte_cnt), 64'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_ready_in", i), 64'(ready_in), 64'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_words_sent", i), 64'(words_sent), 64'(tbl[i].e_sent));
    end

    // Backpressure: word held stable for 5 cycles, exactly one handshake.
    held_s = words_sent;
    step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h03, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h04, 1'b0, 1'b0);
    held_w = 32'h0403_0201;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
      chk("bp_word_out", 64'(word_out), 64'(held_w));
      chk("bp_byte_cnt", 64'(byte_cnt), 64'd4);
      chk("bp_ready_in", 64'(ready_in), 64'd0);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("bp_one_handshake", 64'(words_sent), 64'(held_s + 16'd1));
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("bp_no_second", 64'(words_sent), 64'(held_s + 16'd1));

`ifdef PACKER_CHECKSUM_EN
    step(1'b1, 1'b1, 8'hFF, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h01, 1'b0, 1'b0);
    chk("checksum_word", 64'(checksum), 64'h02);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("checksum_clear", 64'(checksum), 64'h00);
`endif

    // Counter wrap: preload 65535, then one handshake.
    m_sent = 16'hFFFF;
    force dut.sent_q = 16'hFFFF;
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    release dut.sent_q;
    step(1'b1, 1'b1, 8'h7E, 1'b1, 1'b0);
    chk("wrap_pre", 64'(words_sent), 64'hFFFF);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("wrap_zero", 64'(words_sent), 64'h0);

    // Reset while a word is on offer.
    step(1'b1, 1'b1, 8'h10, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h20, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h30, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h40, 1'b0, 1'b0);
    chk("emit_before_rst", 64'(valid_out), 64'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_emit_valid_out", 64'(valid_out), 64'd0);
    chk("rst_emit_ready_in", 64'(ready_in), 64'd1);
    chk("rst_emit_word_out", 64'(word_out), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 9) < 7),
           8'($urandom),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
